// File: rtl/mem_responder.sv
// Memory-side responder for the cache arbiter: single-request line storage with
// a fixed stall latency, a sticky protocol-violation flag and served-request counters.
module mem_responder #(
   parameter int Address_bits = 64,
   parameter int Data_bits    = 512,
   parameter int Depth        = 1024,
   parameter int Latency      = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [Address_bits-1:0] m_addr,
   input  logic [Data_bits-1:0]    m_write_data,
   input  logic                    m_read_en,
   input  logic                    m_write_en,
   output logic [Data_bits-1:0]    m_read_data,
   output logic                    m_stall,
   output logic                    protocol_err,
   output logic [31:0]             reads_served,
   output logic [31:0]             writes_served
);

   localparam int OFF = $clog2(Data_bits / 8);
   localparam int IDX = $clog2(Depth);
   localparam int CW  = $clog2(Latency + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(Latency - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IDX-1:0]       idx_q, idx_d;
   logic                 rd_q, rd_d;
   logic                 wr_q, wr_d;
   logic                 err_q, err_d;
   logic [Data_bits-1:0] rdata_q, rdata_d;
   logic [31:0]          reads_q, reads_d;
   logic [31:0]          writes_q, writes_d;

   logic [Data_bits-1:0] mem_q [Depth];

   logic                 req;
   logic                 accept;
   logic                 done;
   logic [IDX-1:0]       req_idx;
   logic                 unused_addr;

   assign req         = m_read_en | m_write_en;
   assign req_idx     = m_addr[OFF +: IDX];
   assign accept      = (state_q == IDLE) && req;
   assign done        = (state_q == BUSY) && (cnt_q == '0);
   assign unused_addr = ^m_addr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         reads_q  <= '0;
         writes_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         reads_q  <= reads_d;
         writes_q <= writes_d;
      end
   end

   // Storage is deliberately outside reset; a write commits on the accepting edge.
   always_ff @(posedge clk) begin
      if (rst_n && accept && m_write_en) begin
         mem_q[req_idx] <= m_write_data;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = BUSY;
         BUSY:    if (cnt_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      err_d    = err_q | ((state_q == BUSY) && req);
      rdata_d  = rdata_q;
      reads_d  = reads_q;
      writes_d = writes_q;
      if (accept) begin
         cnt_d = CNT_LOAD;
         idx_d = req_idx;
         rd_d  = m_read_en;
         wr_d  = m_write_en;
      end else if ((state_q == BUSY) && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
      // Completion: a read sees the line as already updated by its own write.
      if (done) begin
         if (rd_q) begin
            rdata_d = mem_q[idx_q];
            reads_d = reads_q + 32'd1;
         end
         if (wr_q) begin
            writes_d = writes_q + 32'd1;
         end
      end
   end

   always_comb begin
      m_stall       = (state_q == BUSY);
      m_read_data   = rdata_q;
      protocol_err  = err_q;
      reads_served  = reads_q;
      writes_served = writes_q;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a line-array reference model.
module tb_mem_responder;

   localparam int AW    = 64;
   localparam int DW    = 512;
   localparam int DEPTH = 1024;
   localparam int LAT   = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_write_data;
   logic          m_read_en;
   logic          m_write_en;
   logic [DW-1:0] m_read_data;
   logic          m_stall;
   logic          protocol_err;
   logic [31:0]   reads_served;
   logic [31:0]   writes_served;

   mem_responder #(
      .Address_bits(AW),
      .Data_bits   (DW),
      .Depth       (DEPTH),
      .Latency     (LAT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .m_addr       (m_addr),
      .m_write_data (m_write_data),
      .m_read_en    (m_read_en),
      .m_write_en   (m_write_en),
      .m_read_data  (m_read_data),
      .m_stall      (m_stall),
      .protocol_err (protocol_err),
      .reads_served (reads_served),
      .writes_served(writes_served)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] model_mem [int];
   int            written_idx[$];
   logic [DW-1:0] exp_rdata;
   int unsigned   exp_reads;
   int unsigned   exp_writes;
   logic          exp_err;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int line_of(input logic [AW-1:0] a);
      return int'((a / (DW / 8)) % DEPTH);
   endfunction

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [AW-1:0] addr_for(input int idx);
      logic [AW-1:0] a;
      a = {$urandom, $urandom};
      a[6 +: 10] = idx[9:0];
      return a;
   endfunction

   task automatic model_write(input int idx, input logic [DW-1:0] data);
      if (!model_mem.exists(idx)) written_idx.push_back(idx);
      model_mem[idx] = data;
   endtask

   // Wait (bounded) for stall to drop; returns number of sampled high cycles.
   task automatic wait_stall(output int n);
      n = 0;
      for (int k = 0; k < 50; k++) begin
         if (!m_stall) break;
         n++;
         @(negedge clk);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "/rdata"},  m_read_data, exp_rdata);
      check({tag, "/reads"},  DW'(reads_served), DW'(exp_reads));
      check({tag, "/writes"}, DW'(writes_served), DW'(exp_writes));
      check({tag, "/err"},    DW'(protocol_err), DW'(exp_err));
   endtask

   task automatic request(input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input string tag);
      int idx;
      int n;
      @(negedge clk);
      m_addr       = addr;
      m_write_data = data;
      m_read_en    = rd;
      m_write_en   = wr;
      @(posedge clk);
      idx = line_of(addr);
      if (wr) model_write(idx, data);
      @(negedge clk);
      m_read_en  = 1'b0;
      m_write_en = 1'b0;
      wait_stall(n);
      if (rd) begin
         exp_rdata = model_mem[idx];
         exp_reads++;
      end
      if (wr) exp_writes++;
      check({tag, "/stall_cycles"}, DW'(n), DW'(LAT));
      check_outputs(tag);
   endtask

   initial begin
      logic [DW-1:0] d1, d2, dz;
      int n;
      rst_n        = 1'b0;
      m_addr       = '0;
      m_write_data = '0;
      m_read_en    = 1'b1;
      m_write_en   = 1'b0;
      exp_rdata    = '0;
      exp_reads    = 0;
      exp_writes   = 0;
      exp_err      = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset/stall", DW'(m_stall), '0);
      check_outputs("reset");
      m_read_en = 1'b0;
      rst_n     = 1'b1;

      request(1'b0, 1'b1, 64'h40, {64{8'hA5}}, "wr_a5");
      request(1'b1, 1'b0, 64'h40, '0, "rd_a5");
      check("rd_a5/value", m_read_data, {64{8'hA5}});

      d1 = rand_line();
      request(1'b0, 1'b1, 64'h0, d1, "alias_wr");
      request(1'b1, 1'b0, 64'h10000, '0, "alias_rd");

      d2 = rand_line();
      request(1'b1, 1'b1, 64'h80, d2, "rw_combined");

      for (int it = 0; it < 40; it++) begin
         int op;
         int idx;
         op = int'($urandom_range(0, 2));
         if (written_idx.size() == 0 || op == 0) begin
            idx = int'($urandom_range(0, DEPTH - 1));
            request(1'b0, 1'b1, addr_for(idx), rand_line(), $sformatf("rnd%0d_wr", it));
         end else if (op == 1) begin
            idx = written_idx[$urandom_range(0, written_idx.size() - 1)];
            request(1'b1, 1'b0, addr_for(idx), rand_line(), $sformatf("rnd%0d_rd", it));
         end else begin
            idx = int'($urandom_range(0, DEPTH - 1));
            request(1'b1, 1'b1, addr_for(idx), rand_line(), $sformatf("rnd%0d_rw", it));
         end
      end

      // Second read pulse two cycles into the first must be ignored.
      d1 = rand_line();
      d2 = ~d1;
      request(1'b0, 1'b1, 64'h100, d1, "perr_setup1");
      request(1'b0, 1'b1, 64'h140, d2, "perr_setup2");
      @(negedge clk);
      m_addr    = 64'h100;
      m_read_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      m_read_en = 1'b0;
      @(negedge clk);
      m_addr    = 64'h140;
      m_read_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      m_read_en = 1'b0;
      check("perr/flag_set", DW'(protocol_err), DW'(1));
      wait_stall(n);
      exp_rdata = d1;
      exp_reads++;
      exp_err   = 1'b1;
      check_outputs("perr_done");
      request(1'b0, 1'b1, 64'h180, rand_line(), "perr_sticky");

      // Reset two cycles into a write: the committed line survives.
      dz = rand_line();
      @(negedge clk);
      m_addr       = 64'hC0;
      m_write_data = dz;
      m_write_en   = 1'b1;
      @(posedge clk);
      model_write(line_of(64'hC0), dz);
      @(negedge clk);
      m_write_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      exp_rdata  = '0;
      exp_reads  = 0;
      exp_writes = 0;
      exp_err    = 1'b0;
      check("midrst/stall", DW'(m_stall), '0);
      check_outputs("midrst");
      rst_n = 1'b1;
      request(1'b1, 1'b0, 64'hC0, '0, "midrst_rd");
      check("midrst_rd/value", m_read_data, dz);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time limit, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the cache arbiter's memory port. It accepts the arbiter's one-cycle read/write request pulses, performs the access against an internal line-wide storage array, holds `m_stall` high for a fixed service latency, and presents read data when `m_stall` falls. It sits directly below the arbiter, standing in for main memory in simulation and in small FPGA builds. It also provides a sticky protocol-violation flag and served-request counters for bring-up.

## Interface
- `Address_bits`, 64: width of `m_addr` (byte address).
- `Data_bits`, 512: line width; power of two, ≥ 8.
- `Depth`, 1024: number of lines stored; power of two, ≥ 2.
- `Latency`, 4: number of cycles `m_stall` stays high per request; ≥ 1.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `m_addr`  in  Address_bits  request byte address.
- `m_write_data`  in  Data_bits  write line.
- `m_read_en`  in  1  read request pulse.
- `m_write_en`  in  1  write request pulse.
- `m_read_data`  out  Data_bits  read line, registered.
- `m_stall`  out  1  busy; data valid when it falls.
- `protocol_err`  out  1  sticky: request seen while busy.
- `reads_served`  out  32  completed reads, wraps modulo 2^32.
- `writes_served`  out  32  completed writes, wraps modulo 2^32.

## Operation
- Line index: `m_addr[OFF +: IDX]`, where OFF = log2(Data_bits/8) and IDX = log2(Depth). Upper address bits and offset bits are ignored, so addresses alias modulo Depth lines.
- States:
  - IDLE to BUSY when `m_read_en | m_write_en` is sampled high. Index, read flag, and write flag are captured.
  - BUSY to IDLE when the down-counter reaches 0.
- Write: the storage line is updated at the accepting edge (E0) with `m_write_data`.
- Read: `m_read_data` is loaded from storage at the completion edge.
- Read and write in the same request: the write is committed at E0, and the read returns the newly written line.
- Write-only request: `m_read_data` is unchanged.
- `m_read_data` holds its value until the next read completion.
- Counters increment at the completion edge:
  - `reads_served` when the captured read flag is set.
  - `writes_served` when the captured write flag is set.
  - A read-and-write request increments both.
- Request sampled while BUSY:
  - The request is ignored; no storage update and no capture.
  - `protocol_err` is set and stays set until reset.
- Storage array is not cleared by reset. Contents are undefined after power-up and preserved across reset.

## Timing
- Reset (`rst_n` low at an edge): after that edge, state is IDLE, `m_stall` = 0, `m_read_data` = 0, `protocol_err` = 0, both counters = 0, and the down-counter = 0.
- Reset mid-operation aborts the request with no read-data update and no counter increment. A write already committed at E0 remains in storage.
- Enables are sampled only when `rst_n` is high.
- Request accepted at edge E0:
  - `m_stall` is 1 from E0 through edge E0+Latency, i.e. exactly Latency cycles.
  - At E0+Latency: `m_stall` goes to 0, `m_read_data` updates, and counters update, all together.
- Latency = 1: `m_stall` is high for one cycle. The arbiter ignores stall in the first cycle after its request, so it samples data at E0+2.
- A new request may be accepted at the same edge `m_stall` falls is not allowed. The earliest next acceptance is edge E0+Latency+1, i.e. state is IDLE after completion.
- Down-counter loads Latency−1 at E0 and decrements each BUSY edge; width is clog2(Latency+1).
- Enable pulses longer than one cycle: the second and later cycles fall in BUSY and set `protocol_err`. The arbiter drives single-cycle pulses.

## Test plan
- Reset:
  - Stimulus: hold `rst_n` = 0 for 2 cycles with `m_read_en` = 1.
  - Response: `m_stall` = 0, `m_read_data` = 0, counters = 0, `protocol_err` = 0.
- Write then read (Latency = 4):
  - Stimulus: write 0xA5…A5 to address 0x40, then read address 0x40.
  - Response: `m_stall` is high exactly 4 cycles per request; `m_read_data` = 0xA5…A5 when stall falls; `reads_served` = 1, `writes_served` = 1.
- Aliasing (Depth = 1024, Data_bits = 512):
  - Stimulus: write X at address 0x0, then read address 0x10000 (index 1024 wraps to 0).
  - Response: read returns X.
- Combined read and write:
  - Stimulus: a single pulse with both enables set, data Y, to address 0x80.
  - Response: `m_read_data` = Y at completion; both counters increment by 1.
- Protocol error:
  - Stimulus: second read pulse 2 cycles after the first.
  - Response: `protocol_err` = 1 and stays 1; second address not served; `reads_served` = 1.
- Mid-operation reset:
  - Stimulus: assert `rst_n` low 2 cycles into a write to address 0xC0, then release and read 0xC0.
  - Response: stall drops after the reset edge; `writes_served` = 0; read returns the written data.
